// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - N-port round-robin bus arbiter with slave decode, tenure timeout and data mux
module bus_arbiter_rr #(
  parameter int NUM_DEVICES = 8,
  parameter int D_WIDTH     = 32,
  parameter int C_WIDTH     = 8,
  parameter int ID_W        = 3,
  parameter int TIMEOUT     = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_DEVICES-1:0]         req,
  input  logic [NUM_DEVICES*D_WIDTH-1:0] bus_in,
  input  logic [NUM_DEVICES*C_WIDTH-1:0] ctrl_in,
  output logic [NUM_DEVICES-1:0]         master_ack,
  output logic [NUM_DEVICES-1:0]         slave_en,
  output logic [D_WIDTH-1:0]             bus_out,
  output logic [C_WIDTH-1:0]             ctrl_out,
  output logic [ID_W-1:0]                owner_id,
  output logic                           timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, XFER = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        rr_ptr, rr_nxt, owner_nxt, owner_inc, dst, hi_id, lo_id;
  logic [NUM_DEVICES-1:0] mask, mask_nxt, ack_nxt, slv_nxt;
  logic [NUM_DEVICES-1:0] eligible, hi_oh, lo_oh, dst_oh;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [D_WIDTH-1:0]     owner_data, slave_data;
  logic                   terr_nxt, hi_found, lo_found, slave_drive, req_owner;
  logic                   dst_bad, addr_release, xfer_release, timeout_hit;

  // Owner/slave selection is driven by the one-hot grant registers, so no index decode is needed.
  always_comb begin
    owner_data  = '0;
    slave_data  = '0;
    slave_drive = 1'b0;
    ctrl_out    = '0;
    for (int k = 0; k < NUM_DEVICES; k++) begin
      if (master_ack[k]) owner_data = owner_data | bus_in[k*D_WIDTH +: D_WIDTH];
      if (slave_en[k]) begin
        slave_data  = slave_data | bus_in[k*D_WIDTH +: D_WIDTH];
        slave_drive = slave_drive | ctrl_in[k*C_WIDTH + C_WIDTH - 1];
      end
      ctrl_out = ctrl_out | ctrl_in[k*C_WIDTH +: C_WIDTH];
    end
  end

  // Round-robin pick: lowest eligible index >= rr_ptr, otherwise lowest eligible below it.
  always_comb begin
    eligible = req & ~mask;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    hi_oh    = '0;
    lo_oh    = '0;
    for (int k = NUM_DEVICES - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        if (ID_W'(k) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(k);
          hi_oh    = '0;
          hi_oh[k] = 1'b1;
        end else begin
          lo_found = 1'b1;
          lo_id    = ID_W'(k);
          lo_oh    = '0;
          lo_oh[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_owner    = |(req & master_ack);
    dst          = owner_data[D_WIDTH-1 -: ID_W];
    dst_bad      = ({1'b0, dst} >= (ID_W+1)'(NUM_DEVICES)) || (dst == owner_id);
    timeout_hit  = TO_EN && (cnt == CNT_MAX);
    addr_release = !req_owner || dst_bad;
    xfer_release = !req_owner || timeout_hit;
    owner_inc    = (owner_id == ID_W'(NUM_DEVICES - 1)) ? '0 : owner_id + ID_W'(1);
    for (int k = 0; k < NUM_DEVICES; k++) dst_oh[k] = (dst == ID_W'(k));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      master_ack  <= '0;
      slave_en    <= '0;
      owner_id    <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      mask        <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      master_ack  <= ack_nxt;
      slave_en    <= slv_nxt;
      owner_id    <= owner_nxt;
      timeout_err <= terr_nxt;
      rr_ptr      <= rr_nxt;
      mask        <= mask_nxt;
      cnt         <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|eligible) state_nxt = ADDR;
      ADDR:    state_nxt = addr_release ? IDLE : XFER;
      XFER:    if (xfer_release) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_nxt   = master_ack;
    slv_nxt   = slave_en;
    owner_nxt = owner_id;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    terr_nxt  = 1'b0;
    mask_nxt  = mask & req;
    case (state)
      IDLE: begin
        if (|eligible) begin
          owner_nxt = hi_found ? hi_id : lo_id;
          ack_nxt   = hi_found ? hi_oh : lo_oh;
        end
      end
      ADDR: begin
        if (addr_release) begin
          ack_nxt = '0;
          slv_nxt = '0;
          rr_nxt  = owner_inc;
        end else begin
          slv_nxt = dst_oh;
          cnt_nxt = '0;
        end
      end
      XFER: begin
        if (xfer_release) begin
          ack_nxt = '0;
          slv_nxt = '0;
          rr_nxt  = owner_inc;
          if (req_owner) begin
            terr_nxt = 1'b1;
            mask_nxt = mask_nxt | master_ack;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        ack_nxt = '0;
        slv_nxt = '0;
      end
    endcase
  end

  always_comb begin
    if (state == XFER && slave_drive) bus_out = slave_data;
    else if (state != IDLE)           bus_out = owner_data;
    else                              bus_out = '0;
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - self-checking bench for bus_arbiter_rr (8 ports, 4-bit IDs, timeout 16)
module tb_bus_arbiter_rr;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   req;
  logic [255:0] bus_in;
  logic [63:0]  ctrl_in;
  logic [7:0]   master_ack, slave_en;
  logic [31:0]  bus_out;
  logic [7:0]   ctrl_out;
  logic [3:0]   owner_id;
  logic         timeout_err;

  logic [3:0]   dst_cur = 4'h0;
  logic [7:0]   drv = 8'h00;
  logic         p0_ovr = 1'b0;

  typedef struct packed {
    logic [7:0] ack;
    logic [7:0] sen;
    logic [3:0] oid;
    logic       terr;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic [3:0] dst;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  bus_arbiter_rr #(
    .NUM_DEVICES(8), .D_WIDTH(32), .C_WIDTH(8), .ID_W(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .bus_in(bus_in), .ctrl_in(ctrl_in),
    .master_ack(master_ack), .slave_en(slave_en), .bus_out(bus_out),
    .ctrl_out(ctrl_out), .owner_id(owner_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Port k presents {dst, 20'h0, k, 4'hA}; port 0 can be overridden with slave read data.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      bus_in[k*32 +: 32] = {dst_cur, 20'h0, 4'(k), 4'hA};
      ctrl_in[k*8 +: 8]  = {drv[k], 7'(k)};
    end
    if (p0_ovr) bus_in[31:0] = 32'hDEADBEEF;
  end

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] a, input logic [7:0] s, input logic [3:0] o, input logic t);
    exp_t e;
    e.ack = a; e.sen = s; e.oid = o; e.terr = t;
    return e;
  endfunction

  function automatic void add(input logic rst, input logic [7:0] r, input logic [3:0] d,
                              input logic [7:0] a, input logic [7:0] s, input logic [3:0] o,
                              input logic t);
    vec_t v;
    v.rst = rst; v.req = r; v.dst = d; v.e = mk(a, s, o, t);
    tbl.push_back(v);
  endfunction

  // Drive one cycle of inputs, queue what the registered outputs must be after the edge, then check.
  task automatic cyc(input int tag, input logic rst, input logic [7:0] r, input logic [3:0] d, input exp_t e);
    exp_t got;
    reset   = rst;
    req     = r;
    dst_cur = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("master_ack",  tag, 32'(master_ack),  32'(got.ack));
    chk("slave_en",    tag, 32'(slave_en),    32'(got.sen));
    chk("owner_id",    tag, 32'(owner_id),    32'(got.oid));
    chk("timeout_err", tag, 32'(timeout_err), 32'(got.terr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req   = 8'h00;

    add(1, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    add(1, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    // single master 7 -> slave 0, held 4 cycles
    add(0, 8'h80, 0, 8'h80, 8'h00, 7, 0);
    add(0, 8'h80, 0, 8'h80, 8'h01, 7, 0);
    add(0, 8'h80, 0, 8'h80, 8'h01, 7, 0);
    add(0, 8'h80, 0, 8'h80, 8'h01, 7, 0);
    add(0, 8'h80, 0, 8'h80, 8'h01, 7, 0);
    add(0, 8'h00, 0, 8'h00, 8'h00, 7, 0);
    add(0, 8'h00, 0, 8'h00, 8'h00, 7, 0);
    // rotation over 0,2,7,0; each master briefly drops req to end its tenure
    add(0, 8'h85, 1, 8'h01, 8'h00, 0, 0);
    add(0, 8'h85, 1, 8'h01, 8'h02, 0, 0);
    add(0, 8'h85, 1, 8'h01, 8'h02, 0, 0);
    add(0, 8'h84, 1, 8'h00, 8'h00, 0, 0);
    add(0, 8'h85, 3, 8'h04, 8'h00, 2, 0);
    add(0, 8'h85, 3, 8'h04, 8'h08, 2, 0);
    add(0, 8'h85, 3, 8'h04, 8'h08, 2, 0);
    add(0, 8'h81, 3, 8'h00, 8'h00, 2, 0);
    add(0, 8'h85, 0, 8'h80, 8'h00, 7, 0);
    add(0, 8'h85, 0, 8'h80, 8'h01, 7, 0);
    add(0, 8'h85, 0, 8'h80, 8'h01, 7, 0);
    add(0, 8'h05, 0, 8'h00, 8'h00, 7, 0);
    add(0, 8'h85, 1, 8'h01, 8'h00, 0, 0);
    add(0, 8'h85, 1, 8'h01, 8'h02, 0, 0);
    add(0, 8'h00, 1, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 1, 8'h00, 8'h00, 0, 0);
    // master 6 addresses itself, then an out-of-range slave 9; master 0 follows
    add(0, 8'h40, 6, 8'h40, 8'h00, 6, 0);
    add(0, 8'h40, 6, 8'h00, 8'h00, 6, 0);
    add(0, 8'h40, 9, 8'h40, 8'h00, 6, 0);
    add(0, 8'h40, 9, 8'h00, 8'h00, 6, 0);
    add(0, 8'h41, 1, 8'h01, 8'h00, 0, 0);
    add(0, 8'h41, 1, 8'h01, 8'h02, 0, 0);
    add(0, 8'h00, 1, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 1, 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(i, tbl[i].rst, tbl[i].req, tbl[i].dst, tbl[i].e);
      if (i == 1) chk("bus_out_idle", i, bus_out, 32'h0);
    end

    // master 2 holds req for 40 cycles: 16 XFER cycles then forced release and masking
    for (int i = 1; i <= 40; i++) begin
      if (i == 1)       cyc(100 + i, 0, 8'h04, 3, mk(8'h04, 8'h00, 2, 0));
      else if (i <= 17) cyc(100 + i, 0, 8'h04, 3, mk(8'h04, 8'h08, 2, 0));
      else if (i == 18) cyc(100 + i, 0, 8'h04, 3, mk(8'h00, 8'h00, 2, 1));
      else              cyc(100 + i, 0, 8'h04, 3, mk(8'h00, 8'h00, 2, 0));
    end
    cyc(141, 0, 8'h00, 3, mk(8'h00, 8'h00, 2, 0));
    cyc(142, 0, 8'h04, 3, mk(8'h04, 8'h00, 2, 0));
    cyc(143, 0, 8'h00, 3, mk(8'h00, 8'h00, 2, 0));
    cyc(144, 0, 8'h00, 3, mk(8'h00, 8'h00, 2, 0));

    // master 7 -> slave 0: data mux checks, then reset in the middle of the tenure
    cyc(200, 0, 8'h80, 0, mk(8'h80, 8'h00, 7, 0));
    chk("bus_out_addr", 200, bus_out, 32'h0000007A);
    cyc(201, 0, 8'h80, 0, mk(8'h80, 8'h01, 7, 0));
    cyc(202, 0, 8'h80, 0, mk(8'h80, 8'h01, 7, 0));
    p0_ovr = 1'b1;
    drv    = 8'h01;
    #1;
    chk("bus_out_slave", 202, bus_out, 32'hDEADBEEF);
    chk("ctrl_out_drive", 202, 32'(ctrl_out), 32'h87);
    drv = 8'h00;
    #1;
    chk("bus_out_owner", 202, bus_out, 32'h0000007A);
    chk("ctrl_out_idle", 202, 32'(ctrl_out), 32'h07);
    p0_ovr = 1'b0;
    cyc(203, 1, 8'h80, 0, mk(8'h00, 8'h00, 0, 0));
    chk("bus_out_reset", 203, bus_out, 32'h0);
    cyc(204, 0, 8'h81, 1, mk(8'h01, 8'h00, 0, 0));
    cyc(205, 0, 8'h81, 1, mk(8'h01, 8'h02, 0, 0));
    cyc(206, 0, 8'h00, 1, mk(8'h00, 8'h00, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
